serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing SS_A - SS_B, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- It is the inverse-direction companion to the team's combinational full adder.
- Used where area matters more than latency, e.g. in counters/compare paths of low-rate control logic.
- Operands are captured on a start handshake; the result is presented with a one-cycle done pulse and then held.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; not to be overridden).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous and active-high.
- SS_START  input  1  start request; sampled only when SS_BUSY=0.
- SS_A  input  WIDTH  minuend, captured when start is accepted.
- SS_B  input  WIDTH  subtrahend, captured when start is accepted.
- SS_D  output  WIDTH  difference (A-B mod 2^WIDTH), registered, held until next completion.
- SS_BORROW  output  1  final borrow-out (1 when A<B unsigned), registered, held.
- SS_BUSY  output  1  high while the operation is in progress.
- SS_DONE  output  1  single-cycle pulse when SS_D/SS_BORROW become valid.

Behaviour:
- Reset (async assert, sync release): state=IDLE. SS_D=0, SS_BORROW=0, SS_BUSY=0, SS_DONE=0. Operand shift regs, borrow flop and bit counter are all 0.
- FSM states:
  - IDLE: on SS_START=1, load A/B shift regs, clear borrow flop and counter, go to RUN.
  - RUN: each cycle process bit 0 of the shift regs with d=a^b^bin and bout=(~a&b)|(~(a^b)&bin). Shift d into the result reg from the MSB end, shift operands right, borrow flop <= bout, counter++. After the WIDTH-th bit (counter==WIDTH-1), go to DONE.
  - DONE: SS_D <= result reg, SS_BORROW <= borrow flop, SS_DONE=1 for exactly this cycle. If SS_START=1 here, start the next operation (load and go to RUN); otherwise go to IDLE.
- SS_BUSY=1 in RUN only. SS_DONE=1 in DONE only.
- Latency: with start accepted on edge k, SS_DONE is high in the cycle after edge k+WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- SS_START while busy (RUN) is ignored, with no queuing. SS_A/SS_B changes after capture have no effect.
- SS_D/SS_BORROW change only on DONE entry and hold through IDLE.
- Boundaries:
  - A==B gives D=0, borrow 0.
  - A=0, B=2^WIDTH-1 gives D=1, borrow 1.
  - Counter wrap is impossible; the counter is cleared on every start.
- Reset mid-RUN aborts immediately: no SS_DONE pulse, and outputs return to 0.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_OVF_EN.
- When defined:
  - Extra output SS_OVF (1 bit, reset 0), registered with SS_D on DONE.
  - SS_OVF = signed two's-complement overflow, i.e. (A[MSB]!=B[MSB]) && (D[MSB]!=A[MSB]).
  - The implementation captures the MSBs at start.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package/include serial_sub_defs holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH constant.
- One natural sub-module, full_subtractor: combinational ports a, b, bin to d, bout, instantiated once in the datapath.

Test Plan:
- A=8'd100, B=8'd37, start pulse: SS_BUSY high 8 cycles; SS_DONE 1 cycle, 9 cycles after the start edge; SS_D=8'd63, SS_BORROW=0.
- A=8'd5, B=8'd9: SS_D=8'hFC, SS_BORROW=1. Outputs held through 5 idle cycles with SS_A/SS_B toggling.
- A=B=8'hFF then A=8'h00, B=8'hFF, with start held high continuously: results 8'h00/0, then 8'h01/1, with DONE pulses 9 cycles apart.
- Start at cycle 0, second start with A=1, B=1 at cycle 3 (busy): the second start is ignored and the result is the first operation's only.
- RST asserted mid-RUN (cycle 4) asynchronously: outputs 0 immediately, no DONE. After release, a new op A=8'd10, B=8'd3 gives 8'd7.
- With SERIAL_SUBTRACTOR_OVF_EN: A=8'h80, B=8'h01 gives SS_D=8'h7F, SS_OVF=1. A=8'h10, B=8'h01 gives SS_OVF=0.

Source files
------------

// File: rtl/serial_sub_defs.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_sub_defs;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor computing SS_A - SS_B, LSB first, one bit
// per clock through a single full_subtractor cell and a registered borrow.
// Optional signed-overflow output SS_OVF is built when the macro
// SERIAL_SUBTRACTOR_OVF_EN is defined.
import serial_sub_defs::*;

module serial_subtractor #(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SS_START,
    input  logic [WIDTH-1:0] SS_A,
    input  logic [WIDTH-1:0] SS_B,
    output logic [WIDTH-1:0] SS_D,
    output logic             SS_BORROW,
    output logic             SS_BUSY,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    output logic             SS_OVF,
`endif
    output logic             SS_DONE
);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;    // bits already computed, newest at the top
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             bout_bit;
    logic             last_bit;
    logic             start_ok;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // A start is only honoured when not already computing; DONE allows
    // back-to-back operation without an IDLE gap.
    assign start_ok = SS_START && ((state == S_IDLE) || (state == S_DONE));
    assign SS_BUSY  = (state == S_RUN);
    assign SS_DONE  = (state == S_DONE);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits captured at start, used for the overflow flag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (start_ok) begin
            a_msb <= SS_A[WIDTH-1];
            b_msb <= SS_B[WIDTH-1];
        end
    end

    // Overflow flag registered alongside the difference on DONE entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SS_OVF <= 1'b0;
        end else if ((state == S_RUN) && last_bit) begin
            SS_OVF <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`endif

    // FSM and serial datapath: load on start, then one bit per cycle.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the shift registers are a handful of flops, not a memory
        // array, so resetting them costs nothing and keeps state defined.
        if (RST) begin
            state    <= S_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else if (start_ok) begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state    <= S_RUN;
            a_sr     <= SS_A;
            b_sr     <= SS_B;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= (WIDTH-1)'({d_bit, res_sr} >> 1);
                    borrow_q <= bout_bit;
                    cnt      <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_IDLE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Result registers: loaded once per operation, on DONE entry, then held.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SS_D      <= '0;
            SS_BORROW <= 1'b0;
        end else if ((state == S_RUN) && last_bit) begin
            SS_D      <= {d_bit, res_sr};
            SS_BORROW <= bout_bit;
        end
    end

endmodule
